uart_baud_ctrl: RTL and testbench
=================================

UART_BAUD_CTRL -- requirements
Module: uart_baud_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named `Sys_clock` and `reset`.
REQ-002 Parameters SHALL be (name, default, meaning):
- `DEFAULT_RATE`, 3'b000: baud select applied after reset.
- `SETTLE_CYCLES`, 4: `Sys_clock` cycles the generator is held in reset.
- `LOCK_EDGES`, 2: `Sample_clock` rising edges required to declare lock.
- `LOCK_TIMEOUT`, 65535: `Sys_clock` cycles allowed in LOCK; 16-bit counter.

REQ-003 Ports SHALL be (name, direction, width, meaning):
- `Sys_clock`  in  1  system clock, 8 MHz.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  baud-change request.
- `req_rate`  in  3  requested `Sel_Baud_Rate`.
- `req_ready`  out  1  request accepted when `req_valid` and `req_ready` are both high.
- `busy_tx`  in  1  UART datapath busy; any switch is deferred while high.
- `gen_rst_n`  out  1  drives the generator reset (low = hold).
- `gen_sel_baud`  out  3  drives generator `Sel_Baud_Rate`.
- `gen_sample_clock`  in  1  generator `Sample_clock`, same domain as `Sys_clock`.
- `cur_rate`  out  3  last successfully locked rate.
- `rate_valid`  out  1  generator locked at `cur_rate`.
- `done`  out  1  one-cycle pulse when a request completes.
- `err_timeout`  out  1  level; lock failed.

Function
REQ-004 All outputs SHALL be registered; the FSM SHALL have states BOOT, IDLE, DRAIN, HOLD, LOCK and FAIL.
REQ-005 Reset values SHALL be:
- state = HOLD (boot path), pending = `DEFAULT_RATE`.
- `gen_rst_n` = 0, `gen_sel_baud` = `DEFAULT_RATE`, `cur_rate` = `DEFAULT_RATE`.
- `rate_valid` = 0, `req_ready` = 0, `done` = 0, `err_timeout` = 0.

REQ-006 In IDLE, `req_ready` SHALL be 1 and `rate_valid` SHALL be 1.
- On handshake, `req_rate` SHALL be captured into pending.

REQ-007 A handshake with `req_rate` equal to `cur_rate` in IDLE SHALL pulse `done` the next cycle and remain in IDLE, with `gen_rst_n` untouched.
REQ-008 A handshake with a different rate SHALL enter DRAIN the next cycle, clearing `rate_valid` and `req_ready`.
REQ-009 DRAIN SHALL remain while `busy_tx` is 1 and SHALL enter HOLD on the first cycle `busy_tx` is 0.
REQ-010 HOLD SHALL behave as follows:
- `gen_rst_n` = 0 and `gen_sel_baud` = pending for exactly `SETTLE_CYCLES` cycles.
- The edge detector history SHALL be cleared.
- It SHALL then enter LOCK.

REQ-011 LOCK SHALL behave as follows:
- `gen_rst_n` = 1.
- Rising edges of `gen_sample_clock` (current high, previous low) SHALL be counted.
- On the `LOCK_EDGES`-th edge, the next cycle SHALL be IDLE, with `cur_rate` = pending, `rate_valid` = 1 and a `done` pulse.

REQ-012 If the LOCK cycle count reaches `LOCK_TIMEOUT` before lock, the block SHALL enter FAIL.
- `err_timeout` = 1 and `gen_rst_n` = 0.
- `cur_rate` is unchanged; `rate_valid` = 0.

REQ-013 In FAIL, `req_ready` SHALL be 1.
- A handshake SHALL clear `err_timeout`, capture pending and go to HOLD directly; `busy_tx` is ignored.

REQ-014 `req_valid` SHALL be ignored (no capture) whenever `req_ready` is 0.
- The requester SHALL hold `req_valid` until acceptance.

REQ-015 If lock and timeout occur on the same cycle, lock SHALL win.
REQ-016 All counters SHALL saturate, never wrap.
- `SETTLE_CYCLES` = 0 SHALL be treated as 1.

Reset
REQ-017 Reset asserted in any state, including mid-HOLD or mid-LOCK, SHALL restore the REQ-005 values on the next edge.
- After reset, the block SHALL run HOLD → LOCK with `DEFAULT_RATE`, with no request needed.

REQ-018 Pending requests SHALL be discarded on reset.

Structure
REQ-019 Shared package `uart_pkg` SHALL hold:
- the FSM state encoding,
- `BAUD_SEL_W` = 3,
- the `DEFAULT_RATE` constant.

REQ-020 Rising-edge detection plus the saturating edge counter SHALL be one sub-module, `uart_tick_detect`.
- Inputs: clear, enable, `gen_sample_clock`.
- Output: edge count.

REQ-021 The `uart_clk_gen` instance SHALL live outside this block; the bench connects it.

Verification
REQ-022 Boot: release reset with `uart_clk_gen` attached at 8 MHz → `gen_rst_n` low 4 cycles, then high; `rate_valid` = 1 with `cur_rate` = 000 after 2 `Sample_clock` edges.
REQ-023 Switch: request 3'b011 with `busy_tx` high for 10 cycles → `gen_rst_n` stays 1 for those 10 cycles, then is low 4 cycles with `gen_sel_baud` = 011; `done` pulses once; `cur_rate` = 011.
REQ-024 Same-rate: request 3'b011 while at 011 → `done` the next cycle; `gen_rst_n` never drops; `rate_valid` never drops.
REQ-025 Timeout: `LOCK_TIMEOUT` = 100, `gen_sample_clock` tied to 0, request 101 →
- `err_timeout` = 1 after 100 LOCK cycles, with `cur_rate` still 011;
- a retry with a working clock clears the error and locks.

REQ-026 Reset mid-LOCK while switching to 110 → `cur_rate` = 000 and `gen_sel_baud` = 000; the boot sequence repeats.
REQ-027 Back-pressure: `req_valid` pulses during DRAIN/HOLD/LOCK → no capture; the final `cur_rate` equals the first accepted rate.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the baud-rate controller
package uart_pkg;

    localparam int BAUD_SEL_W = 3;
    localparam logic [BAUD_SEL_W-1:0] DEFAULT_RATE = 3'b000;
    localparam int EDGE_CNT_W = 8;
    localparam int LOCK_CNT_W = 16;
    localparam int HOLD_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HOLD  = 3'd3,
        ST_LOCK  = 3'd4,
        ST_FAIL  = 3'd5
    } state_e;

    // Zero-length windows would make HOLD or LOCK vanish; clamp to one cycle.
    function automatic int min_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/uart_tick_detect.sv
// rtl/uart_tick_detect.sv - rising-edge detector with saturating edge counter
module uart_tick_detect
    import uart_pkg::*;
#(
    parameter int CNT_W = EDGE_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             sample_clk_i,
    output logic [CNT_W-1:0] edge_cnt_o
);

    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rise;

    assign rise = enable_i && sample_clk_i && !prev_q;

    always_comb begin
        cnt_d = cnt_q;
        if (rise && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else if (enable_i) begin
            prev_q <= sample_clk_i;
            cnt_q  <= cnt_d;
        end
    end

    // Count includes an edge seen this cycle so the controller can react on it.
    assign edge_cnt_o = cnt_d;

endmodule

// File: rtl/uart_baud_ctrl.sv
// rtl/uart_baud_ctrl.sv - sequences baud-rate switches of an external UART clock generator
module uart_baud_ctrl #(
    parameter logic [uart_pkg::BAUD_SEL_W-1:0] DEFAULT_RATE  = uart_pkg::DEFAULT_RATE,
    parameter int                              SETTLE_CYCLES = 4,
    parameter int                              LOCK_EDGES    = 2,
    parameter int                              LOCK_TIMEOUT  = 65535
) (
    input  logic                            Sys_clock,
    input  logic                            reset,
    input  logic                            req_valid,
    input  logic [uart_pkg::BAUD_SEL_W-1:0] req_rate,
    output logic                            req_ready,
    input  logic                            busy_tx,
    output logic                            gen_rst_n,
    output logic [uart_pkg::BAUD_SEL_W-1:0] gen_sel_baud,
    input  logic                            gen_sample_clock,
    output logic [uart_pkg::BAUD_SEL_W-1:0] cur_rate,
    output logic                            rate_valid,
    output logic                            done,
    output logic                            err_timeout
);

    import uart_pkg::*;

    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST    = HOLD_CNT_W'(min_one(SETTLE_CYCLES) - 1);
    localparam logic [LOCK_CNT_W-1:0] TIMEOUT_LAST = LOCK_CNT_W'(min_one(LOCK_TIMEOUT) - 1);
    localparam logic [EDGE_CNT_W-1:0] LOCK_EDGES_C = EDGE_CNT_W'(LOCK_EDGES);

    state_e                  state_q, state_d;
    logic [BAUD_SEL_W-1:0]   pending_q, pending_d;
    logic [HOLD_CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [LOCK_CNT_W-1:0]   lock_cnt_q, lock_cnt_d;

    logic                    gen_rst_n_q, gen_rst_n_d;
    logic [BAUD_SEL_W-1:0]   gen_sel_q, gen_sel_d;
    logic [BAUD_SEL_W-1:0]   cur_rate_q, cur_rate_d;
    logic                    rate_valid_q, rate_valid_d;
    logic                    req_ready_q, req_ready_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    handshake;
    logic                    locked;
    logic [EDGE_CNT_W-1:0]   edge_cnt;

    uart_tick_detect #(
        .CNT_W (EDGE_CNT_W)
    ) u_tick_detect (
        .clk_i        (Sys_clock),
        .rst_i        (reset),
        .clear_i      (state_q == ST_HOLD),
        .enable_i     (state_q == ST_LOCK),
        .sample_clk_i (gen_sample_clock),
        .edge_cnt_o   (edge_cnt)
    );

    assign handshake = req_valid && req_ready_q;
    assign locked    = (edge_cnt >= LOCK_EDGES_C);

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        hold_cnt_d = '0;
        lock_cnt_d = '0;
        cur_rate_d = cur_rate_q;
        done_d     = 1'b0;

        case (state_q)
            ST_BOOT: begin
                pending_d = DEFAULT_RATE;
                state_d   = ST_HOLD;
            end
            ST_IDLE: begin
                if (handshake) begin
                    pending_d = req_rate;
                    if (req_rate == cur_rate_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!busy_tx) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q >= HOLD_LAST) begin
                    state_d = ST_LOCK;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_LOCK: begin
                // Lock is checked first so it wins over a timeout on the same cycle.
                if (locked) begin
                    state_d    = ST_IDLE;
                    cur_rate_d = pending_q;
                    done_d     = 1'b1;
                end else if (lock_cnt_q >= TIMEOUT_LAST) begin
                    state_d = ST_FAIL;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            ST_FAIL: begin
                if (handshake) begin
                    pending_d = req_rate;
                    state_d   = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        gen_rst_n_d  = (state_d == ST_IDLE) || (state_d == ST_DRAIN) || (state_d == ST_LOCK);
        gen_sel_d    = (state_d == ST_HOLD) ? pending_d : gen_sel_q;
        rate_valid_d = (state_d == ST_IDLE);
        req_ready_d  = (state_d == ST_IDLE) || (state_d == ST_FAIL);
        err_d        = (state_d == ST_FAIL);
    end

    always_ff @(posedge Sys_clock) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            pending_q    <= DEFAULT_RATE;
            hold_cnt_q   <= '0;
            lock_cnt_q   <= '0;
            gen_rst_n_q  <= 1'b0;
            gen_sel_q    <= DEFAULT_RATE;
            cur_rate_q   <= DEFAULT_RATE;
            rate_valid_q <= 1'b0;
            req_ready_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            hold_cnt_q   <= hold_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            gen_rst_n_q  <= gen_rst_n_d;
            gen_sel_q    <= gen_sel_d;
            cur_rate_q   <= cur_rate_d;
            rate_valid_q <= rate_valid_d;
            req_ready_q  <= req_ready_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign gen_rst_n    = gen_rst_n_q;
    assign gen_sel_baud = gen_sel_q;
    assign cur_rate     = cur_rate_q;
    assign rate_valid   = rate_valid_q;
    assign done         = done_q;
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// tb/tb_uart_baud_ctrl.sv - randomized self-checking bench for uart_baud_ctrl
`timescale 1ns/1ps
module tb_uart_baud_ctrl;

    localparam int          SETTLE  = 4;
    localparam int          EDGES   = 2;
    localparam int          TIMEOUT = 100;
    localparam logic [2:0]  DEF     = 3'b000;

    logic       Sys_clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [2:0] req_rate;
    logic       req_ready;
    logic       busy_tx;
    logic       gen_rst_n;
    logic [2:0] gen_sel_baud;
    logic       gen_sample_clock;
    logic [2:0] cur_rate;
    logic       rate_valid;
    logic       done;
    logic       err_timeout;

    int vectors     = 0;
    int miscompares = 0;

    always #62.5 Sys_clock = ~Sys_clock;

    uart_baud_ctrl #(
        .DEFAULT_RATE  (DEF),
        .SETTLE_CYCLES (SETTLE),
        .LOCK_EDGES    (EDGES),
        .LOCK_TIMEOUT  (TIMEOUT)
    ) dut (
        .Sys_clock        (Sys_clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_rate         (req_rate),
        .req_ready        (req_ready),
        .busy_tx          (busy_tx),
        .gen_rst_n        (gen_rst_n),
        .gen_sel_baud     (gen_sel_baud),
        .gen_sample_clock (gen_sample_clock),
        .cur_rate         (cur_rate),
        .rate_valid       (rate_valid),
        .done             (done),
        .err_timeout      (err_timeout)
    );

    // Stand-in clock generator: half period of (sel + 2) cycles, silenced by gen_dead.
    logic       gen_dead = 1'b0;
    logic [3:0] gcnt     = 4'd0;
    logic       gsc      = 1'b0;
    always @(posedge Sys_clock) begin
        if (!gen_rst_n || gen_dead) begin
            gcnt <= 4'd0;
            gsc  <= 1'b0;
        end else if (gcnt >= {1'b0, gen_sel_baud} + 4'd1) begin
            gcnt <= 4'd0;
            gsc  <= ~gsc;
        end else begin
            gcnt <= gcnt + 4'd1;
        end
    end
    assign gen_sample_clock = gsc;

    // Expected outputs after the most recent clock edge
    bit         armed = 1'b0;
    logic       e_rst_n, e_valid, e_ready, e_done, e_err;
    logic [2:0] e_sel, e_cur;

    task automatic tick(output bit r);
        @(posedge Sys_clock);
        r = reset;
        if (r) begin
            e_rst_n = 1'b0; e_sel = DEF; e_cur = DEF;
            e_valid = 1'b0; e_ready = 1'b0; e_done = 1'b0; e_err = 1'b0;
            armed   = 1'b1;
        end
    endtask

    // Generator hold then lock attempt; HOLD was entered at the edge just taken.
    // st: 0 locked, 1 timed out, 2 interrupted by reset
    task automatic establish(input logic [2:0] rate, output int st);
        bit   r;
        int   edges;
        int   cyc;
        logic prev;
        logic s;
        e_rst_n = 1'b0; e_sel = rate; e_valid = 1'b0; e_ready = 1'b0;
        e_done  = 1'b0; e_err = 1'b0;
        for (int k = 1; k < SETTLE; k++) begin
            tick(r);
            if (r) begin st = 2; return; end
        end
        tick(r);
        if (r) begin st = 2; return; end
        e_rst_n = 1'b1;
        edges = 0; cyc = 0; prev = 1'b0;
        forever begin
            tick(r);
            if (r) begin st = 2; return; end
            s = gen_sample_clock;
            if (s && !prev) edges++;
            prev = s;
            cyc++;
            if (edges >= EDGES) begin
                e_cur = rate; e_valid = 1'b1; e_ready = 1'b1; e_done = 1'b1;
                st = 0; return;
            end
            if (cyc >= TIMEOUT) begin
                e_err = 1'b1; e_rst_n = 1'b0; e_ready = 1'b1;
                st = 1; return;
            end
        end
    endtask

    initial begin : model
        bit         r;
        int         st;
        bit         failed;
        logic [2:0] rt;
        r = 1'b0;
        forever begin
            while (!r) tick(r);
            establish(DEF, st);
            if (st == 2) begin r = 1'b1; continue; end
            failed = (st == 1);
            r = 1'b0;
            while (!r) begin
                tick(r);
                if (r) break;
                e_done = 1'b0;
                if (req_valid && e_ready) begin
                    rt = req_rate;
                    if (!failed && rt == e_cur) begin
                        e_done = 1'b1;
                    end else begin
                        if (!failed) begin
                            e_valid = 1'b0; e_ready = 1'b0;
                            do tick(r); while (!r && busy_tx);
                            if (r) break;
                        end
                        establish(rt, st);
                        if (st == 2) begin r = 1'b1; break; end
                        failed = (st == 1);
                    end
                end
            end
        end
    end

    always @(negedge Sys_clock) begin
        if (armed) begin
            vectors++;
            if ({gen_rst_n, gen_sel_baud, cur_rate, rate_valid, req_ready, done, err_timeout} !==
                {e_rst_n, e_sel, e_cur, e_valid, e_ready, e_done, e_err}) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t got rst_n=%b sel=%0d cur=%0d valid=%b ready=%b done=%b err=%b want rst_n=%b sel=%0d cur=%0d valid=%b ready=%b done=%b err=%b",
                         $time, gen_rst_n, gen_sel_baud, cur_rate, rate_valid, req_ready, done, err_timeout,
                         e_rst_n, e_sel, e_cur, e_valid, e_ready, e_done, e_err);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic send(input logic [2:0] rate);
        int n;
        n = 0;
        req_rate  = rate;
        req_valid = 1'b1;
        do begin
            @(posedge Sys_clock);
            n++;
        end while (!req_ready && n < 500);
        #1 req_valid = 1'b0;
        if (n >= 500) check("send_accept", int'(req_ready), 1);
    endtask

    task automatic wait_settled(output int dcnt);
        int n;
        n = 0; dcnt = 0;
        do begin
            @(negedge Sys_clock);
            dcnt += int'(done);
            n++;
        end while (!rate_valid && !err_timeout && n < 1000);
        if (n >= 1000) check("settle_bound", int'(rate_valid), 1);
    endtask

    task automatic do_reset();
        @(negedge Sys_clock);
        reset = 1'b1;
        repeat (2) @(posedge Sys_clock);
        #1 reset = 1'b0;
    endtask

    task automatic boot_check(input string tag);
        int n;
        int d;
        @(negedge Sys_clock);
        check({tag, "_rst_cur"},   int'(cur_rate), 0);
        check({tag, "_rst_sel"},   int'(gen_sel_baud), 0);
        check({tag, "_rst_ready"}, int'(req_ready), 0);
        n = 0;
        while (!gen_rst_n && n < 50) begin
            n++;
            @(negedge Sys_clock);
        end
        check({tag, "_hold_len"}, n, 4);
        wait_settled(d);
        check({tag, "_cur"},   int'(cur_rate), 0);
        check({tag, "_valid"}, int'(rate_valid), 1);
    endtask

    initial begin : stim
        int         n;
        int         s;
        int         d;
        logic [2:0] rt;

        reset = 1'b1; req_valid = 1'b0; req_rate = 3'b000; busy_tx = 1'b0;
        repeat (3) @(posedge Sys_clock);
        #1 reset = 1'b0;
        boot_check("boot");

        // Switch to 011 while the datapath stays busy for ten cycles
        busy_tx = 1'b1;
        send(3'b011);
        n = 0;
        repeat (10) begin
            @(negedge Sys_clock);
            n += int'(gen_rst_n);
        end
        check("drain_rst_n_high", n, 10);
        busy_tx = 1'b0;
        @(negedge Sys_clock);
        n = 0; s = 0;
        while (!gen_rst_n && n < 50) begin
            n++;
            if (gen_sel_baud == 3'b011) s++;
            @(negedge Sys_clock);
        end
        check("switch_hold_len", n, 4);
        check("switch_hold_sel", s, 4);
        wait_settled(d);
        repeat (3) begin
            @(negedge Sys_clock);
            d += int'(done);
        end
        check("switch_done_cnt", d, 1);
        check("switch_cur", int'(cur_rate), 3);

        // Same-rate request completes without touching the generator
        send(3'b011);
        @(negedge Sys_clock);
        check("same_done", int'(done), 1);
        n = 0;
        repeat (5) begin
            @(negedge Sys_clock);
            n += int'(!gen_rst_n) + int'(!rate_valid);
        end
        check("same_no_drop", n, 0);

        // Lock timeout with a silent generator, then a working retry
        gen_dead = 1'b1;
        send(3'b101);
        n = 0;
        while (gen_rst_n && n < 200) begin n++; @(negedge Sys_clock); end
        n = 0;
        while (!gen_rst_n && n < 200) begin n++; @(negedge Sys_clock); end
        n = 0;
        while (!err_timeout && n < 1000) begin n++; @(negedge Sys_clock); end
        check("timeout_lock_cycles", n, 100);
        check("timeout_err", int'(err_timeout), 1);
        check("timeout_cur", int'(cur_rate), 3);
        check("timeout_valid", int'(rate_valid), 0);
        check("timeout_rst_n", int'(gen_rst_n), 0);
        gen_dead = 1'b0;
        send(3'b101);
        wait_settled(d);
        check("retry_cur", int'(cur_rate), 5);
        check("retry_err", int'(err_timeout), 0);

        // Reset in the middle of LOCK while heading for 110
        gen_dead = 1'b1;
        send(3'b110);
        n = 0;
        while (gen_rst_n && n < 200) begin n++; @(negedge Sys_clock); end
        n = 0;
        while (!gen_rst_n && n < 200) begin n++; @(negedge Sys_clock); end
        repeat (5) @(negedge Sys_clock);
        do_reset();
        gen_dead = 1'b0;
        boot_check("reboot");

        // Request pulses while busy must not be captured
        busy_tx = 1'b1;
        send(3'b010);
        n = 0;
        while (!rate_valid && n < 1000) begin
            @(negedge Sys_clock);
            n++;
            if (n == 6) busy_tx = 1'b0;
            if (!rate_valid) begin
                req_valid = !req_ready && ($urandom_range(0, 1) == 1);
                req_rate  = 3'($urandom_range(0, 7));
            end
        end
        req_valid = 1'b0;
        check("backpressure_cur", int'(cur_rate), 2);

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            rt       = 3'($urandom_range(0, 7));
            gen_dead = ($urandom_range(0, 5) == 0);
            busy_tx  = $urandom_range(0, 1);
            send(rt);
            repeat ($urandom_range(0, 12)) begin
                @(negedge Sys_clock);
                busy_tx = $urandom_range(0, 1);
            end
            busy_tx = 1'b0;
            wait_settled(d);
            gen_dead = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                do_reset();
                boot_check("rand_boot");
            end
        end

        repeat (5) @(negedge Sys_clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #12_000_000;
        $display("FAIL watchdog: simulation did not finish, got no end want end");
        $fatal(1);
    end

endmodule
